// File: rtl/vga_fb_fetch_if.sv
// Bus bundle between the frame-buffer fetch controller, the memory read port
// and the write side of the pixel FIFO.
interface vga_fb_fetch_if #(
    parameter int AW = 32,
    parameter int DW = 16
);
    logic          mem_read;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          fifo_write;
    logic [DW-1:0] fifo_din;
    logic          fifo_full;
    logic          fifo_afull;

    modport master (
        output mem_read, mem_addr, fifo_write, fifo_din,
        input  mem_ready, mem_rvalid, mem_rdata, fifo_full, fifo_afull
    );

    modport slave (
        input  mem_read, mem_addr, fifo_write, fifo_din,
        output mem_ready, mem_rvalid, mem_rdata, fifo_full, fifo_afull
    );
endinterface

// File: rtl/vga_fb_fetch.sv
// Frame-buffer fetch controller: streams one frame of pixel words from memory
// into the VGA pixel FIFO, throttled by FIFO almost-full and a read credit limit.
module vga_fb_fetch #(
    parameter int AW         = 32,
    parameter int DW         = 16,
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480,
    parameter int MAX_OUTSTD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [AW-1:0] fb_base,
    vga_fb_fetch_if.master bus,
    output logic          busy,
    output logic          frame_done,
    output logic          err_overrun,
    output logic          err_late
);
    localparam int TOTAL = H_ACT * V_ACT;
    localparam int CW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_base;
    logic [CW-1:0] r_req_cnt, r_wr_cnt;
    logic [3:0]    r_outstd;
    logic          r_hold;
    logic          r_wr_pend;
    logic [DW-1:0] r_din;
    logic          r_frame_done, r_err_overrun, r_err_late;

    logic          w_mem_read, w_accept, w_rvalid_act, w_ret, w_start, w_last_wr;
    logic [AW-1:0] w_mem_addr;

    // A frame_start coinciding with the frame_done cycle belongs to the old frame.
    assign w_start      = frame_start && (r_state == S_IDLE) && !r_frame_done;
    assign w_accept     = w_mem_read && bus.mem_ready;
    assign w_rvalid_act = bus.mem_rvalid && (r_state != S_IDLE);
    assign w_ret        = w_rvalid_act && (r_outstd != 4'd0);
    assign w_last_wr    = (r_state == S_DRAIN) && w_rvalid_act &&
                          (r_wr_cnt == CW'(TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = S_FETCH;
            S_FETCH: if (w_accept && (r_req_cnt == CW'(TOTAL - 1))) w_next = S_DRAIN;
            S_DRAIN: if (w_last_wr) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A request already on the bus is held until accepted, regardless of credits/afull.
    always_comb begin
        w_mem_read = 1'b0;
        w_mem_addr = '0;
        if (r_state == S_FETCH) begin
            w_mem_read = r_hold ||
                         ((r_outstd < 4'(MAX_OUTSTD)) && !bus.fifo_afull);
            w_mem_addr = r_base + AW'(r_req_cnt) * AW'(DW / 8);
        end
    end

    assign bus.mem_read   = w_mem_read;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.fifo_write = r_wr_pend && !bus.fifo_full;
    assign bus.fifo_din   = r_din;
    assign busy           = (r_state != S_IDLE);
    assign frame_done     = r_frame_done;
    assign err_overrun    = r_err_overrun;
    assign err_late       = r_err_late;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            r_base        <= '0;
            r_req_cnt     <= '0;
            r_wr_cnt      <= '0;
            r_outstd      <= '0;
            r_hold        <= 1'b0;
            r_wr_pend     <= 1'b0;
            r_din         <= '0;
            r_frame_done  <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_late    <= 1'b0;
        end else begin
            r_hold       <= w_mem_read && !bus.mem_ready;
            r_wr_pend    <= w_rvalid_act;
            r_frame_done <= w_last_wr;
            if (w_rvalid_act) r_din <= bus.mem_rdata;

            if (w_start) begin
                r_base    <= fb_base;
                r_req_cnt <= '0;
                r_wr_cnt  <= '0;
            end else begin
                if (w_accept)     r_req_cnt <= r_req_cnt + CW'(1);
                if (w_rvalid_act) r_wr_cnt  <= r_wr_cnt + CW'(1);
            end

            unique case ({w_accept, w_ret})
                2'b10:   r_outstd <= r_outstd + 4'd1;
                2'b01:   r_outstd <= r_outstd - 4'd1;
                default: r_outstd <= r_outstd;
            endcase

            // Dropped words still count toward the frame so it always terminates.
            if (r_wr_pend && bus.fifo_full) r_err_overrun <= 1'b1;
            if (frame_start && ((r_state != S_IDLE) || r_frame_done)) r_err_late <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench for vga_fb_fetch: small 4x2 frame, latency-configurable memory
// model, FIFO back-pressure, late frame starts and mid-frame reset.
module tb_vga_fb_fetch;
    localparam int AW = 32, DW = 16, H = 4, V = 2, MO = 4, TOTAL = H * V;

    logic          clk = 1'b0;
    logic          rst, frame_start;
    logic [AW-1:0] fb_base;
    logic          busy, frame_done, err_overrun, err_late;

    vga_fb_fetch_if #(.AW(AW), .DW(DW)) bus ();

    vga_fb_fetch #(.AW(AW), .DW(DW), .H_ACT(H), .V_ACT(V), .MAX_OUTSTD(MO)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .fb_base(fb_base),
        .bus(bus), .busy(busy), .frame_done(frame_done),
        .err_overrun(err_overrun), .err_late(err_late)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int due; } req_t;

    int            errors = 0, checks = 0;
    int            cyc = 0, lat = 1;
    req_t          q[$];
    logic [AW-1:0] acc_log[$];
    logic [DW-1:0] wr_log[$];
    int            fd_cnt = 0, tb_out = 0, max_out = 0, rd_hi_at_max = 0;
    logic          busy_at_fd = 1'b1;

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a[15:0] ^ a[31:16] ^ 16'h5A5A;
    endfunction

    function automatic int addr_errs(input logic [AW-1:0] base);
        int n = (acc_log.size() == TOTAL) ? 0 : 1;
        for (int i = 0; i < acc_log.size() && i < TOTAL; i++)
            if (acc_log[i] !== base + AW'(2 * i)) n++;
        return n;
    endfunction

    function automatic int data_errs(input logic [AW-1:0] base);
        int n = (wr_log.size() == TOTAL) ? 0 : 1;
        for (int i = 0; i < wr_log.size() && i < TOTAL; i++)
            if (wr_log[i] !== mdata(base + AW'(2 * i))) n++;
        return n;
    endfunction

    // Memory: in-order responses, one per cycle, `lat` cycles after acceptance.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst && q.size() > 0 && q[0].due <= cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = mdata(q[0].addr);
                void'(q.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
            end
            @(negedge clk);
            if (!rst && bus.mem_read && bus.mem_ready)
                q.push_back('{bus.mem_addr, cyc + lat});
        end
    end

    // Monitor sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            tb_out = 0;
        end else begin
            if (bus.mem_read && tb_out >= MO) rd_hi_at_max++;
            if (bus.mem_read && bus.mem_ready) begin
                acc_log.push_back(bus.mem_addr);
                tb_out++;
            end
            if (bus.mem_rvalid && tb_out > 0) tb_out--;
            if (tb_out > max_out) max_out = tb_out;
            if (bus.fifo_write) wr_log.push_back(bus.fifo_din);
            if (frame_done) begin
                fd_cnt++;
                busy_at_fd = busy;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs();
        acc_log.delete();
        wr_log.delete();
        fd_cnt = 0; max_out = 0; rd_hi_at_max = 0; busy_at_fd = 1'b1;
    endtask

    task automatic start_frame(input logic [AW-1:0] base);
        tick(1);
        fb_base = base; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (fd_cnt > 0) ok = 1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_done: frame_done not seen, required within 300 cycles", name); end
        tick(5);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 100 && acc_log.size() < n; i++) @(negedge clk);
        checks++;
        if (acc_log.size() < n) begin errors++; $display("FAIL wait_acc: accepts=%0d required>=%0d", acc_log.size(), n); end
    endtask

    task automatic check_frame(input string name, input logic [AW-1:0] base);
        int ae, de;
        ae = addr_errs(base);
        de = data_errs(base);
        checks++;
        if (ae !== 0) begin errors++; $display("FAIL %s_addr: %0d bad of %0d accepts, required 0 bad of %0d", name, ae, acc_log.size(), TOTAL); end
        checks++;
        if (de !== 0) begin errors++; $display("FAIL %s_data: %0d bad of %0d writes, required 0 bad of %0d", name, de, wr_log.size(), TOTAL); end
        checks++;
        if (fd_cnt !== 1) begin errors++; $display("FAIL %s_fd_cnt: got %0d required 1", name, fd_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b0; fb_base = '0;
        bus.mem_ready = 1'b1; bus.fifo_afull = 1'b0; bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, frame_done, err_overrun, err_late, bus.mem_read, bus.fifo_write} !== 6'b0) begin
            errors++; $display("FAIL reset_ctl: got %b required 000000",
                {busy, frame_done, err_overrun, err_late, bus.mem_read, bus.fifo_write});
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.fifo_din !== '0) begin
            errors++; $display("FAIL reset_data: addr=%h din=%h required 0/0", bus.mem_addr, bus.fifo_din);
        end
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        lat = 1; clear_logs();
        start_frame(32'h0000_1000);
        wait_done("basic");
        check_frame("basic", 32'h0000_1000);
        checks++;
        if (busy_at_fd !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b required 0", busy_at_fd); end
        checks++;
        if (err_overrun !== 1'b0 || err_late !== 1'b0) begin
            errors++; $display("FAIL basic_errs: overrun=%b late=%b required 0/0", err_overrun, err_late);
        end
    endtask

    task automatic test_latency();
        lat = 10; clear_logs();
        start_frame(32'hFFFF_FFF8);
        wait_done("latency");
        check_frame("latency", 32'hFFFF_FFF8);
        checks++;
        if (max_out !== MO) begin errors++; $display("FAIL latency_max_outstd: got %0d required %0d", max_out, MO); end
        checks++;
        if (rd_hi_at_max !== 0) begin errors++; $display("FAIL latency_read_at_limit: got %0d cycles required 0", rd_hi_at_max); end
    endtask

    task automatic test_afull();
        int acc0, acc1, wr1;
        lat = 3; clear_logs();
        start_frame(32'h0000_2000);
        wait_acc(3);
        tick(1);
        bus.fifo_afull = 1'b1;
        acc0 = acc_log.size();
        tick(20);
        acc1 = acc_log.size();
        wr1  = wr_log.size();
        bus.fifo_afull = 1'b0;
        checks++;
        if (acc1 !== acc0) begin errors++; $display("FAIL afull_no_req: accepts %0d required %0d", acc1, acc0); end
        checks++;
        if (wr1 !== acc1) begin errors++; $display("FAIL afull_inflight: writes %0d required %0d", wr1, acc1); end
        wait_done("afull");
        check_frame("afull", 32'h0000_2000);
        checks++;
        if (err_overrun !== 1'b0) begin errors++; $display("FAIL afull_overrun: got %b required 0", err_overrun); end
    endtask

    task automatic test_stall();
        int bad = 0;
        lat = 2; clear_logs();
        bus.mem_ready = 1'b0;
        start_frame(32'h0000_3000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_3000) bad++;
            tick(1);
            if (i == 1) bus.fifo_afull = 1'b1;
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0000_3000) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles required 0", bad); end
        tick(3);
        checks++;
        if (acc_log.size() !== 1 || acc_log[0] !== 32'h0000_3000) begin
            errors++; $display("FAIL stall_accept: count=%0d required 1 at 00003000", acc_log.size());
        end
        bus.fifo_afull = 1'b0;
        wait_done("stall");
        check_frame("stall", 32'h0000_3000);
    endtask

    task automatic test_late_overrun();
        logic [DW-1:0] exp_w[$];
        int bad = 0;
        lat = 1; clear_logs();
        start_frame(32'h0000_4000);
        tick(2);
        fb_base = 32'h0000_9000; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (err_late !== 1'b1) begin errors++; $display("FAIL late_flag: got %b required 1", err_late); end
        for (int i = 0; i < 100 && wr_log.size() < 3; i++) @(negedge clk);
        tick(1);
        bus.fifo_full = 1'b1;
        tick(1);
        bus.fifo_full = 1'b0;
        wait_done("late");
        checks++;
        if (err_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b required 1", err_overrun); end
        for (int i = 0; i < TOTAL; i++) if (i != 3) exp_w.push_back(mdata(32'h0000_4000 + AW'(2 * i)));
        if (wr_log.size() != exp_w.size()) bad++;
        for (int i = 0; i < wr_log.size() && i < exp_w.size(); i++) if (wr_log[i] !== exp_w[i]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL overrun_data: %0d bad, writes=%0d required 7 with word 3 dropped", bad, wr_log.size()); end
        checks++;
        if (addr_errs(32'h0000_4000) !== 0) begin errors++; $display("FAIL late_addr: frame addresses differ from base 00004000"); end
        checks++;
        if (fd_cnt !== 1) begin errors++; $display("FAIL late_fd_cnt: got %0d required 1", fd_cnt); end
    endtask

    task automatic test_reset_mid();
        lat = 3; clear_logs();
        start_frame(32'h0000_5000);
        wait_acc(3);
        tick(1);
        rst = 1'b1;
        q.delete();
        tick(1);
        @(negedge clk);
        checks++;
        if ({busy, frame_done, err_overrun, err_late, bus.mem_read, bus.fifo_write} !== 6'b0 ||
            bus.mem_addr !== '0) begin
            errors++; $display("FAIL midrst_outputs: got %b addr=%h required 000000 addr=0",
                {busy, frame_done, err_overrun, err_late, bus.mem_read, bus.fifo_write}, bus.mem_addr);
        end
        tick(1);
        rst = 1'b0;
        q.delete();
        clear_logs();
        tick(3);
        checks++;
        if (acc_log.size() !== 0) begin errors++; $display("FAIL midrst_idle: accepts %0d required 0", acc_log.size()); end
        start_frame(32'h0000_6000);
        wait_done("midrst");
        check_frame("midrst", 32'h0000_6000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_afull();
        test_stall();
        test_late_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
